bridge_n: RTL and testbench
===========================

BRIDGE_N -- requirements
Module: bridge_n

Interface
REQ-001 Parameters SHALL be (name, default, meaning): N_DEV, 2, device count, legal 1..6; DEV_BASE, 28'h00007F0, PrAddr[31:4] of device 0, device i at DEV_BASE+i; CTRL_BASE, 28'h00007FF, PrAddr[31:4] of bridge control window; TIMEOUT, 16, max ACCESS cycles, legal 2..255.
REQ-002 Ports SHALL be (name, direction, width, meaning): clk in 1 clock; reset in 1 sync active-high reset; PrReq in 1 CPU request; PrAddr in 32 CPU address; PrWD in 32 CPU write data; PrWE in 1 CPU write; PrRD out 32 read data; PrReady out 1 completion pulse; PrErr out 1 error with PrReady; HWInt out 6 interrupt lines [7:2]; DEV_Addr out 2 word offset [3:2]; DEV_WD out 32 device write data; DEV_Sel out N_DEV one-hot select; DEV_WE out N_DEV per-device write enable; DEV_RD in 32*N_DEV device read data, device i at [32i+31:32i]; DEV_Ready in N_DEV device done; DEV_Irq in N_DEV level interrupt requests.
REQ-003 Design SHALL use one clock, clk; reset SHALL be synchronous and active-high, sampled only on rising clk.

Function
REQ-004 FSM SHALL have states IDLE, ACCESS, RESP.
REQ-005 IDLE with PrReq=1 SHALL latch PrAddr[3:2], PrWD, PrWE and decode PrAddr[31:4]: device hit -> ACCESS; CTRL_BASE hit -> RESP, no error; otherwise -> RESP with PrErr=1, PrRD=0.
REQ-006 In ACCESS, DEV_Sel[i] and DEV_WE[i] (=latched PrWE) SHALL be held constant from latched values; DEV_Addr, DEV_WD SHALL be latched values.
REQ-007 ACCESS SHALL exit to RESP on the first cycle DEV_Ready[i]=1 for selected i, capturing DEV_RD slice i into PrRD (0 on writes); DEV_Ready of unselected devices SHALL be ignored.
REQ-008 Cycle counter SHALL start at 0 on ACCESS entry; if DEV_Ready[i] absent through the TIMEOUT-th ACCESS cycle, FSM SHALL go to RESP with PrErr=1, PrRD=0.
REQ-009 RESP SHALL last exactly one cycle with PrReady=1, then IDLE; PrRD, PrErr valid only while PrReady=1, otherwise 0.
REQ-010 Minimum latency SHALL be: control/unmapped 1 cycle request-to-PrReady; device access 2 cycles (ready in first ACCESS cycle); maximum TIMEOUT+1.
REQ-011 PrReq SHALL be ignored outside IDLE; CPU holds request stable until PrReady; a PrReq high in the cycle after RESP is a new request.
REQ-012 Control window: offset 0 IMASK (RW, N_DEV bits, upper bits read 0); offset 4 IPEND (read; write-1-to-clear); offsets 8, C read 0, writes ignored, no error.
REQ-013 IPEND[i] SHALL set on a DEV_Irq[i] rising edge (registered previous value), independent of IMASK.
REQ-014 Set and W1C on the same bit in the same cycle SHALL leave the bit set.
REQ-015 HWInt[2+i] SHALL equal registered IPEND[i] & IMASK[i]; HWInt bits >= 2+N_DEV SHALL be 0.
REQ-016 Control reads SHALL return register values sampled in the IDLE accept cycle.

Reset
REQ-017 Reset SHALL force IDLE, counter 0, IMASK 0, IPEND 0, DEV_Irq history 0, and all outputs 0: PrRD, PrReady, PrErr, HWInt, DEV_Sel, DEV_WE, DEV_Addr, DEV_WD.
REQ-018 Reset mid-ACCESS SHALL abort with no PrReady, DEV_Sel/DEV_WE low next cycle.
REQ-019 A DEV_Irq already high when reset deasserts SHALL not set IPEND (no rising edge).

Structure
REQ-020 Shared package SHALL hold FSM state encoding, control offsets (IMASK=2'b00, IPEND=2'b01), and default DEV_BASE/CTRL_BASE constants.
REQ-021 Interrupt edge detect/pending/mask logic SHALL be sub-module bridge_irq, parametrised by N_DEV.

Verification
REQ-022 Read dev1 at 0x00007F14, DEV_Ready[1]=1 after 3 ACCESS cycles, DEV_RD[63:32]=32'h1234_5678 -> DEV_Sel=2'b10, DEV_Addr=2'b01, PrReady one cycle later, PrRD=32'h1234_5678, PrErr=0.
REQ-023 Write 32'hA5A5_A5A5 to 0x00007F08 -> DEV_WE=2'b01, DEV_WD=32'hA5A5_A5A5 until DEV_Ready[0]; DEV_WE[1] stays 0.
REQ-024 Read 0x00008000 -> PrReady next cycle, PrErr=1, PrRD=0, DEV_Sel stays 0.
REQ-025 No DEV_Ready, TIMEOUT=16 -> PrReady with PrErr=1 on cycle 17 after request.
REQ-026 Write IMASK=2'b11, pulse DEV_Irq[1] -> HWInt=6'b000010; W1C IPEND=2'b10 same cycle as new rising edge -> bit stays set; separate W1C -> HWInt=0.
REQ-027 Reset in 2nd ACCESS cycle -> all outputs 0 next cycle; next request completes normally.

Source files
------------

// File: rtl/bridge_n_pkg.sv
// bridge_n_pkg: shared state encoding, control offsets and default address windows
package bridge_n_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
    localparam logic [1:0] OFF_IMASK = 2'b00;
    localparam logic [1:0] OFF_IPEND = 2'b01;
    localparam logic [27:0] DEF_DEV_BASE = 28'h00007F0;
    localparam logic [27:0] DEF_CTRL_BASE = 28'h00007FF;
endpackage

// File: rtl/bridge_irq.sv
// bridge_irq: interrupt edge detect, pending (W1C) and mask registers
module bridge_irq #(
    parameter int N_DEV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_DEV-1:0] irq_i,
    input  logic             mask_wr_i,
    input  logic [N_DEV-1:0] mask_i,
    input  logic             clr_i,
    input  logic [N_DEV-1:0] clr_mask_i,
    output logic [N_DEV-1:0] mask_o,
    output logic [N_DEV-1:0] pend_o,
    output logic [5:0]       hwint_o
);
    logic [N_DEV-1:0] prev_q, mask_q, mask_d, pend_q, pend_d, rise;
    logic arm_q;
    // history is only trusted from the second cycle out of reset, so a line held high through reset is no edge
    assign rise = arm_q ? irq_i & ~prev_q : '0;
    assign mask_d = mask_wr_i ? mask_i : mask_q;
    assign pend_d = (pend_q & ~(clr_i ? clr_mask_i : '0)) | rise;
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
            arm_q  <= 1'b0;
            mask_q <= '0;
            pend_q <= '0;
        end else begin
            prev_q <= irq_i;
            arm_q  <= 1'b1;
            mask_q <= mask_d;
            pend_q <= pend_d;
        end
    end
    assign mask_o = mask_q;
    assign pend_o = pend_q;
    assign hwint_o = 6'(pend_q & mask_q);
endmodule

// File: rtl/bridge_n.sv
// bridge_n: CPU-to-N-device bus bridge with timeout and interrupt control window
module bridge_n import bridge_n_pkg::*; #(
    parameter int          N_DEV     = 2,
    parameter logic [27:0] DEV_BASE  = DEF_DEV_BASE,
    parameter logic [27:0] CTRL_BASE = DEF_CTRL_BASE,
    parameter int          TIMEOUT   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  PrReq,
    input  logic [31:0]           PrAddr,
    input  logic [31:0]           PrWD,
    input  logic                  PrWE,
    output logic [31:0]           PrRD,
    output logic                  PrReady,
    output logic                  PrErr,
    output logic [5:0]            HWInt,
    output logic [1:0]            DEV_Addr,
    output logic [31:0]           DEV_WD,
    output logic [N_DEV-1:0]      DEV_Sel,
    output logic [N_DEV-1:0]      DEV_WE,
    input  logic [32*N_DEV-1:0]   DEV_RD,
    input  logic [N_DEV-1:0]      DEV_Ready,
    input  logic [N_DEV-1:0]      DEV_Irq
);
    state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d, rd_q, rd_d, dev_rd, ctrl_rd;
    logic we_q, we_d, err_q, err_d;
    logic [N_DEV-1:0] sel_q, sel_d, imask, ipend;
    logic [27:0] dev_off;
    logic accept, dev_hit, ctrl_hit, dev_rdy, mask_wr, pend_clr, unused;
    assign unused = ^PrAddr[1:0];
    assign accept = state_q == IDLE && PrReq;
    assign dev_off = PrAddr[31:4] - DEV_BASE;
    assign dev_hit = dev_off < 28'(N_DEV);
    assign ctrl_hit = !dev_hit && PrAddr[31:4] == CTRL_BASE;
    assign mask_wr = accept && ctrl_hit && PrWE && PrAddr[3:2] == OFF_IMASK;
    assign pend_clr = accept && ctrl_hit && PrWE && PrAddr[3:2] == OFF_IPEND;
    assign ctrl_rd = PrAddr[3:2] == OFF_IMASK ? 32'(imask) :
                     PrAddr[3:2] == OFF_IPEND ? 32'(ipend) : '0;
    assign dev_rdy = |(DEV_Ready & sel_q);
    always_comb begin
        dev_rd = '0;
        for (int i = 0; i < N_DEV; i++) dev_rd |= sel_q[i] ? DEV_RD[32*i +: 32] : '0;
    end
    bridge_irq #(.N_DEV(N_DEV)) u_irq (
        .clk       (clk),
        .reset     (reset),
        .irq_i     (DEV_Irq),
        .mask_wr_i (mask_wr),
        .mask_i    (PrWD[N_DEV-1:0]),
        .clr_i     (pend_clr),
        .clr_mask_i(PrWD[N_DEV-1:0]),
        .mask_o    (imask),
        .pend_o    (ipend),
        .hwint_o   (HWInt)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        we_d    = we_q;
        sel_d   = sel_q;
        rd_d    = '0;
        err_d   = 1'b0;
        if (accept) begin
            addr_d = PrAddr[3:2];
            wd_d   = PrWD;
            we_d   = PrWE;
            cnt_d  = '0;
            if (dev_hit) begin
                state_d = ACCESS;
                sel_d   = N_DEV'(1) << dev_off[2:0];
            end else begin
                state_d = RESP;
                err_d   = !ctrl_hit;
                rd_d    = ctrl_hit && !PrWE ? ctrl_rd : '0;
            end
        end else if (state_q == ACCESS) begin
            // ready wins over timeout when both land on the last allowed cycle
            if (dev_rdy || cnt_q == 8'(TIMEOUT - 1)) begin
                state_d = RESP;
                sel_d   = '0;
                err_d   = !dev_rdy;
                rd_d    = dev_rdy && !we_q ? dev_rd : '0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end
    assign PrRD     = rd_q;
    assign PrErr    = err_q;
    assign PrReady  = state_q == RESP;
    assign DEV_Addr = addr_q;
    assign DEV_WD   = wd_q;
    assign DEV_Sel  = sel_q;
    assign DEV_WE   = sel_q & {N_DEV{we_q}};
endmodule

// File: tb/tb_bridge_n.sv
// tb_bridge_n: directed self-checking bench for bridge_n
module tb_bridge_n;
    logic clk = 0, reset = 1, PrReq = 0, PrWE = 0;
    logic [31:0] PrAddr = '0, PrWD = '0, PrRD, DEV_WD;
    logic PrReady, PrErr;
    logic [5:0] HWInt;
    logic [1:0] DEV_Addr, DEV_Sel, DEV_WE;
    logic [1:0] DEV_Ready = '0, DEV_Irq = '0;
    logic [63:0] DEV_RD = '0;
    int n_chk = 0, n_fail = 0;

    bridge_n dut (
        .clk(clk), .reset(reset), .PrReq(PrReq), .PrAddr(PrAddr), .PrWD(PrWD), .PrWE(PrWE),
        .PrRD(PrRD), .PrReady(PrReady), .PrErr(PrErr), .HWInt(HWInt), .DEV_Addr(DEV_Addr),
        .DEV_WD(DEV_WD), .DEV_Sel(DEV_Sel), .DEV_WE(DEV_WE), .DEV_RD(DEV_RD),
        .DEV_Ready(DEV_Ready), .DEV_Irq(DEV_Irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic ctrl_access(input logic [31:0] a, input logic we, input logic [31:0] wd);
        PrAddr = a; PrWE = we; PrWD = wd; PrReq = 1;
        tick();
        n_chk++; if (PrReady !== 1'b1 || PrErr !== 1'b0) begin n_fail++; $display("FAIL ctrl_ready: got rdy=%b err=%b exp rdy=1 err=0", PrReady, PrErr); end
    endtask

    task automatic test_reset;
        reset = 1;
        tick(2);
        n_chk++; if ({PrRD, PrReady, PrErr, HWInt, DEV_Sel, DEV_WE, DEV_Addr, DEV_WD} !== '0) begin n_fail++;
            $display("FAIL reset_outs: got rd=%h rdy=%b err=%b hw=%b sel=%b we=%b a=%b wd=%h exp all 0", PrRD, PrReady, PrErr, HWInt, DEV_Sel, DEV_WE, DEV_Addr, DEV_WD); end
        reset = 0;
        tick();
    endtask

    task automatic test_dev_read;
        DEV_RD = {32'h1234_5678, 32'hDEAD_BEEF};
        PrAddr = 32'h0000_7F14; PrWE = 0; PrReq = 1;
        tick();
        n_chk++; if (DEV_Sel !== 2'b10 || DEV_Addr !== 2'b01 || DEV_WE !== 2'b00) begin n_fail++; $display("FAIL rd_sel: got sel=%b addr=%b we=%b exp sel=10 addr=01 we=00", DEV_Sel, DEV_Addr, DEV_WE); end
        DEV_Ready = 2'b01;
        tick();
        DEV_Ready = 2'b00;
        n_chk++; if (PrReady !== 1'b0 || DEV_Sel !== 2'b10) begin n_fail++; $display("FAIL rd_ignore_other: got rdy=%b sel=%b exp rdy=0 sel=10", PrReady, DEV_Sel); end
        tick();
        DEV_Ready = 2'b10;
        tick();
        DEV_Ready = 2'b00;
        n_chk++; if (PrReady !== 1'b1 || PrRD !== 32'h1234_5678 || PrErr !== 1'b0) begin n_fail++; $display("FAIL rd_resp: got rdy=%b rd=%h err=%b exp rdy=1 rd=12345678 err=0", PrReady, PrRD, PrErr); end
        PrReq = 0;
        tick();
        n_chk++; if (PrReady !== 1'b0 || PrRD !== '0 || DEV_Sel !== 2'b00) begin n_fail++; $display("FAIL rd_after: got rdy=%b rd=%h sel=%b exp 0", PrReady, PrRD, DEV_Sel); end
    endtask

    task automatic test_dev_write;
        PrAddr = 32'h0000_7F08; PrWD = 32'hA5A5_A5A5; PrWE = 1; PrReq = 1;
        tick();
        n_chk++; if (DEV_WE !== 2'b01 || DEV_Sel !== 2'b01 || DEV_WD !== 32'hA5A5_A5A5 || DEV_Addr !== 2'b10) begin n_fail++;
            $display("FAIL wr_drive: got we=%b sel=%b wd=%h a=%b exp we=01 sel=01 wd=a5a5a5a5 a=10", DEV_WE, DEV_Sel, DEV_WD, DEV_Addr); end
        DEV_Ready = 2'b10;
        tick();
        n_chk++; if (DEV_WE !== 2'b01 || PrReady !== 1'b0) begin n_fail++; $display("FAIL wr_hold: got we=%b rdy=%b exp we=01 rdy=0", DEV_WE, PrReady); end
        DEV_Ready = 2'b01;
        tick();
        DEV_Ready = 2'b00;
        n_chk++; if (PrReady !== 1'b1 || PrRD !== '0 || PrErr !== 1'b0 || DEV_WE !== 2'b00) begin n_fail++;
            $display("FAIL wr_resp: got rdy=%b rd=%h err=%b we=%b exp rdy=1 rd=0 err=0 we=00", PrReady, PrRD, PrErr, DEV_WE); end
        PrReq = 0; PrWE = 0;
        tick();
    endtask

    task automatic test_unmapped;
        PrAddr = 32'h0000_8000; PrWE = 0; PrReq = 1;
        tick();
        n_chk++; if (PrReady !== 1'b1 || PrErr !== 1'b1 || PrRD !== '0 || DEV_Sel !== 2'b00) begin n_fail++;
            $display("FAIL unmapped: got rdy=%b err=%b rd=%h sel=%b exp rdy=1 err=1 rd=0 sel=00", PrReady, PrErr, PrRD, DEV_Sel); end
        PrReq = 0;
        tick();
        n_chk++; if (PrReady !== 1'b0 || PrErr !== 1'b0) begin n_fail++; $display("FAIL unmapped_after: got rdy=%b err=%b exp 0 0", PrReady, PrErr); end
    endtask

    task automatic test_timeout;
        int k;
        PrAddr = 32'h0000_7F00; PrWE = 0; PrReq = 1;
        for (k = 1; k <= 40; k++) begin
            tick();
            if (PrReady) break;
        end
        n_chk++; if (k !== 17 || PrErr !== 1'b1 || PrRD !== '0) begin n_fail++; $display("FAIL timeout: got cycle=%0d err=%b rd=%h exp cycle=17 err=1 rd=0", k, PrErr, PrRD); end
        PrReq = 0;
        tick();
        PrAddr = 32'h0000_7F10; PrReq = 1;
        tick(16);
        DEV_Ready = 2'b10;
        tick();
        DEV_Ready = 2'b00;
        n_chk++; if (PrReady !== 1'b1 || PrErr !== 1'b0 || PrRD !== 32'h1234_5678) begin n_fail++;
            $display("FAIL ready_last_cycle: got rdy=%b err=%b rd=%h exp rdy=1 err=0 rd=12345678", PrReady, PrErr, PrRD); end
        PrReq = 0;
        tick();
    endtask

    task automatic test_irq;
        ctrl_access(32'h0000_7FF0, 1, 32'hFFFF_FFFF);
        PrReq = 0; tick();
        ctrl_access(32'h0000_7FF0, 0, 0);
        n_chk++; if (PrRD !== 32'h3) begin n_fail++; $display("FAIL imask_rd: got %h exp 00000003", PrRD); end
        PrReq = 0; tick();
        DEV_Irq = 2'b10; tick();
        DEV_Irq = 2'b00; tick();
        n_chk++; if (HWInt !== 6'b000010) begin n_fail++; $display("FAIL hwint_set: got %b exp 000010", HWInt); end
        ctrl_access(32'h0000_7FF4, 0, 0);
        n_chk++; if (PrRD !== 32'h2) begin n_fail++; $display("FAIL ipend_rd: got %h exp 00000002", PrRD); end
        PrReq = 0; tick();
        DEV_Irq = 2'b10;
        ctrl_access(32'h0000_7FF4, 1, 32'h2);
        PrReq = 0; DEV_Irq = 2'b00; tick();
        n_chk++; if (HWInt !== 6'b000010) begin n_fail++; $display("FAIL set_beats_clr: got %b exp 000010", HWInt); end
        ctrl_access(32'h0000_7FF4, 1, 32'h2);
        PrReq = 0; tick();
        n_chk++; if (HWInt !== 6'b000000) begin n_fail++; $display("FAIL w1c: got %b exp 000000", HWInt); end
        ctrl_access(32'h0000_7FF0, 1, 32'h2);
        PrReq = 0; tick();
        DEV_Irq = 2'b01; tick();
        DEV_Irq = 2'b00; tick();
        n_chk++; if (HWInt !== 6'b000000) begin n_fail++; $display("FAIL masked: got %b exp 000000", HWInt); end
        ctrl_access(32'h0000_7FF4, 0, 0);
        n_chk++; if (PrRD !== 32'h1) begin n_fail++; $display("FAIL masked_pend: got %h exp 00000001", PrRD); end
        PrReq = 0; tick();
        ctrl_access(32'h0000_7FF8, 0, 0);
        n_chk++; if (PrRD !== '0) begin n_fail++; $display("FAIL off8_rd: got %h exp 0", PrRD); end
        PrReq = 0; PrWE = 0; tick();
    endtask

    task automatic test_reset_mid;
        PrAddr = 32'h0000_7F14; PrWE = 0; PrReq = 1; DEV_Ready = 2'b00;
        tick(2);
        reset = 1; DEV_Irq = 2'b01;
        tick();
        n_chk++; if ({PrRD, PrReady, PrErr, HWInt, DEV_Sel, DEV_WE, DEV_Addr, DEV_WD} !== '0) begin n_fail++;
            $display("FAIL reset_mid: got rd=%h rdy=%b err=%b hw=%b sel=%b we=%b a=%b wd=%h exp all 0", PrRD, PrReady, PrErr, HWInt, DEV_Sel, DEV_WE, DEV_Addr, DEV_WD); end
        reset = 0; DEV_Ready = 2'b10;
        tick();
        n_chk++; if (DEV_Sel !== 2'b10 || PrReady !== 1'b0) begin n_fail++; $display("FAIL post_reset_sel: got sel=%b rdy=%b exp sel=10 rdy=0", DEV_Sel, PrReady); end
        tick();
        DEV_Ready = 2'b00;
        n_chk++; if (PrReady !== 1'b1 || PrRD !== 32'h1234_5678 || PrErr !== 1'b0) begin n_fail++;
            $display("FAIL post_reset_rd: got rdy=%b rd=%h err=%b exp rdy=1 rd=12345678 err=0", PrReady, PrRD, PrErr); end
        PrReq = 0; tick(2);
        ctrl_access(32'h0000_7FF4, 0, 0);
        n_chk++; if (PrRD !== '0) begin n_fail++; $display("FAIL irq_through_reset: got %h exp 0", PrRD); end
        PrReq = 0; DEV_Irq = 2'b00; tick();
    endtask

    initial begin
        test_reset();
        test_dev_read();
        test_dev_write();
        test_unmapped();
        test_timeout();
        test_irq();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
